// File: rtl/trap_request_arbiter_if.sv
// -----------------------------------------------------------------------------
// trap_request_arbiter_if
//   Bundles the request, handler-control and trap-context signals of
//   trap_request_arbiter. The slave modport is the arbiter side. The master
//   modport is the environment side: pipeline stages, interrupt controller,
//   CSR requester and handler FSM.
//
//   Handshake semantics:
//   A requester raises exc_valid_i[i] or csr_req_i and holds it, with its
//   payload stable, until the arbiter answers.
//   - For an exception, the answer is a one-cycle exc_consumed_o[i] pulse.
//   - For a CSR access, the answer is a one-cycle csr_grant_o pulse.
//   The pulse is the acceptance. The requester must drop or replace the request
//   in the cycle that follows the pulse. Interrupts (irq_i) are level signals
//   and have no acceptance pulse. mret_i is a one-cycle event.
//
// Signals
//   exc_valid_i / exc_cause_i / exc_pc_i / exc_tval_i : per-stage exceptions
//   irq_i {MEI,MSI,MTI}, mstatus_mie_i, irq_pc_i       : interrupt inputs
//   csr_req_i, mret_i                                  : CSR request, trap return
//   csr_grant_o, csr_busy_o, csr_access_req_o          : CSR sequencing
//   trap_taken_o, exc_consumed_o, trap_active_o        : trap control
//   mcause_o, mepc_o, mtval_o                          : latched trap context
// -----------------------------------------------------------------------------
interface trap_request_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int XLEN    = 64,
  parameter int CAUSE_W = 5
);
  logic [NUM_SRC-1:0]         exc_valid_i;
  logic [NUM_SRC*CAUSE_W-1:0] exc_cause_i;
  logic [NUM_SRC*XLEN-1:0]    exc_pc_i;
  logic [NUM_SRC*XLEN-1:0]    exc_tval_i;
  logic [2:0]                 irq_i;
  logic                       mstatus_mie_i;
  logic [XLEN-1:0]            irq_pc_i;
  logic                       csr_req_i;
  logic                       mret_i;
  logic                       csr_grant_o;
  logic                       csr_busy_o;
  logic                       csr_access_req_o;
  logic                       trap_taken_o;
  logic [NUM_SRC-1:0]         exc_consumed_o;
  logic                       trap_active_o;
  logic [CAUSE_W:0]           mcause_o;
  logic [XLEN-1:0]            mepc_o;
  logic [XLEN-1:0]            mtval_o;

  modport slave (
    input  exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i,
    input  irq_i, mstatus_mie_i, irq_pc_i, csr_req_i, mret_i,
    output csr_grant_o, csr_busy_o, csr_access_req_o, trap_taken_o,
    output exc_consumed_o, trap_active_o, mcause_o, mepc_o, mtval_o
  );

  modport master (
    output exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i,
    output irq_i, mstatus_mie_i, irq_pc_i, csr_req_i, mret_i,
    input  csr_grant_o, csr_busy_o, csr_access_req_o, trap_taken_o,
    input  exc_consumed_o, trap_active_o, mcause_o, mepc_o, mtval_o
  );
endinterface

// File: rtl/trap_request_arbiter.sv
// -----------------------------------------------------------------------------
// trap_request_arbiter
//   Chooses one request per cycle in front of the exception-handler FSM. The
//   candidates are per-stage synchronous exceptions, masked machine interrupts
//   and CSR accesses. Priority runs from exceptions (lowest index first), to
//   MEI, MSI and MTI, to CSR access. The module latches the winning trap
//   context and holds it until mret. A granted CSR access occupies a
//   fixed-length busy window.
//
// Ports
//   clock_i, reset_ni : clock, asynchronous active-low reset
//   bus (slave)       : all request and response signals, described in
//                       trap_request_arbiter_if
//   state_o           : current FSM state (0 IDLE, 1 TRAP_ACTIVE, 2 CSR_BUSY)
// -----------------------------------------------------------------------------
module trap_request_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int XLEN       = 64,
  parameter int CAUSE_W    = 5,
  parameter int CSR_CYCLES = 2
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  trap_request_arbiter_if.slave  bus,
  output logic [1:0]             state_o
);

  localparam int CNT_W = (CSR_CYCLES > 1) ? $clog2(CSR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CSR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_TRAP_ACTIVE = 2'd1,
    ST_CSR_BUSY    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ret_q, ret_d;       // CSR access began inside a trap
  logic                 taken_q, taken_d;
  logic                 grant_q, grant_d;
  logic [NUM_SRC-1:0]   consumed_q, consumed_d;
  logic [CAUSE_W:0]     mcause_q, mcause_d;
  logic [XLEN-1:0]      mepc_q, mepc_d;
  logic [XLEN-1:0]      mtval_q, mtval_d;

  // Winning trap candidate. It is used only while IDLE.
  logic                 win_valid;
  logic [NUM_SRC-1:0]   win_onehot;
  logic [CAUSE_W:0]     win_cause;
  logic [XLEN-1:0]      win_epc;
  logic [XLEN-1:0]      win_tval;

  always_comb begin
    win_valid  = 1'b0;
    win_onehot = '0;
    win_cause  = '0;
    win_epc    = '0;
    win_tval   = '0;
    // The scan runs from high to low index so the lowest valid source is
    // written last and therefore wins.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.exc_valid_i[i]) begin
        win_valid  = 1'b1;
        win_onehot = NUM_SRC'(1) << i;
        win_cause  = {1'b0, bus.exc_cause_i[i*CAUSE_W +: CAUSE_W]};
        win_epc    = bus.exc_pc_i[i*XLEN +: XLEN];
        win_tval   = bus.exc_tval_i[i*XLEN +: XLEN];
      end
    end
    if (!win_valid && bus.mstatus_mie_i && (bus.irq_i != 3'b000)) begin
      win_valid = 1'b1;
      win_epc   = bus.irq_pc_i;
      if (bus.irq_i[2])      win_cause = {1'b1, CAUSE_W'(11)};  // MEI
      else if (bus.irq_i[1]) win_cause = {1'b1, CAUSE_W'(3)};   // MSI
      else                   win_cause = {1'b1, CAUSE_W'(7)};   // MTI
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ret_d      = ret_q;
    taken_d    = 1'b0;
    grant_d    = 1'b0;
    consumed_d = '0;
    mcause_d   = mcause_q;
    mepc_d     = mepc_q;
    mtval_d    = mtval_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          taken_d    = 1'b1;
          consumed_d = win_onehot;
          mcause_d   = win_cause;
          mepc_d     = win_epc;
          mtval_d    = win_tval;
          state_d    = ST_TRAP_ACTIVE;
        end else if (bus.csr_req_i) begin
          grant_d = 1'b1;
          cnt_d   = CNT_LOAD;
          ret_d   = 1'b0;
          state_d = ST_CSR_BUSY;
        end
      end
      ST_TRAP_ACTIVE: begin
        // mret takes precedence. A CSR request that is still pending is
        // granted from IDLE in a later cycle.
        if (bus.mret_i) begin
          state_d = ST_IDLE;
        end else if (bus.csr_req_i) begin
          grant_d = 1'b1;
          cnt_d   = CNT_LOAD;
          ret_d   = 1'b1;
          state_d = ST_CSR_BUSY;
        end
      end
      ST_CSR_BUSY: begin
        // An mret during the window cancels the return to TRAP_ACTIVE. The
        // exit decision uses the updated flag.
        ret_d = ret_q & ~bus.mret_i;
        if (cnt_q == '0) begin
          state_d = ret_d ? ST_TRAP_ACTIVE : ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ret_q      <= 1'b0;
      taken_q    <= 1'b0;
      grant_q    <= 1'b0;
      consumed_q <= '0;
      mcause_q   <= '0;
      mepc_q     <= '0;
      mtval_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ret_q      <= ret_d;
      taken_q    <= taken_d;
      grant_q    <= grant_d;
      consumed_q <= consumed_d;
      mcause_q   <= mcause_d;
      mepc_q     <= mepc_d;
      mtval_q    <= mtval_d;
    end
  end

  assign bus.trap_taken_o     = taken_q;
  assign bus.exc_consumed_o   = consumed_q;
  assign bus.csr_grant_o      = grant_q;
  assign bus.csr_access_req_o = grant_q;
  assign bus.csr_busy_o       = (state_q == ST_CSR_BUSY);
  // Trap context remains active during a CSR access issued from inside the trap.
  assign bus.trap_active_o    = (state_q == ST_TRAP_ACTIVE) ||
                                ((state_q == ST_CSR_BUSY) && ret_q);
  assign bus.mcause_o         = mcause_q;
  assign bus.mepc_o           = mepc_q;
  assign bus.mtval_o          = mtval_q;
  assign state_o              = state_q;

endmodule

// File: tb/tb_trap_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_trap_request_arbiter
//   Directed bench for trap_request_arbiter. A behavioural model describes the
//   arbiter in terms of "in trap", "CSR cycles left" and "return to trap". A
//   queue of expected trap records acts as the scoreboard.
// -----------------------------------------------------------------------------
module tb_trap_request_arbiter;
  localparam int NUM_SRC    = 4;
  localparam int XLEN       = 64;
  localparam int CAUSE_W    = 5;
  localparam int CSR_CYCLES = 2;
  localparam int REC_W      = CAUSE_W + 1 + 2 * XLEN;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trap_request_arbiter_if #(.NUM_SRC(NUM_SRC), .XLEN(XLEN), .CAUSE_W(CAUSE_W)) bus();
  logic [1:0] dut_state;

  trap_request_arbiter #(
    .NUM_SRC(NUM_SRC), .XLEN(XLEN), .CAUSE_W(CAUSE_W), .CSR_CYCLES(CSR_CYCLES)
  ) dut (
    .clock_i (clk),
    .reset_ni(rst_n),
    .bus     (bus),
    .state_o (dut_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.exc_valid_i   = '0;
    bus.exc_cause_i   = '0;
    bus.exc_pc_i      = '0;
    bus.exc_tval_i    = '0;
    bus.irq_i         = 3'b000;
    bus.mstatus_mie_i = 1'b0;
    bus.irq_pc_i      = '0;
    bus.csr_req_i     = 1'b0;
    bus.mret_i        = 1'b0;
  endtask

  task automatic set_exc(input int idx, input logic [CAUSE_W-1:0] cause,
                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tval);
    bus.exc_cause_i[idx*CAUSE_W +: CAUSE_W] = cause;
    bus.exc_pc_i[idx*XLEN +: XLEN]          = pc;
    bus.exc_tval_i[idx*XLEN +: XLEN]        = tval;
  endtask

  // ---------------- behavioural model ----------------
  logic               m_in_trap;
  int                 m_csr_left;   // busy cycles still to be shown
  logic               m_ret;
  logic               m_taken, m_grant;
  logic [NUM_SRC-1:0] m_consumed;
  logic [CAUSE_W:0]   m_cause;
  logic [XLEN-1:0]    m_epc, m_tval;
  logic [REC_W-1:0]   exp_q[$];
  int                 m_win;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_trap = 0; m_csr_left = 0; m_ret = 0; m_taken = 0; m_grant = 0;
      m_consumed = '0; m_cause = '0; m_epc = '0; m_tval = '0;
      exp_q.delete();
    end else begin
      m_taken = 0; m_grant = 0; m_consumed = '0;
      if (m_csr_left > 0) begin
        if (bus.mret_i) m_ret = 0;
        m_csr_left--;
        if (m_csr_left == 0) m_in_trap = m_ret;
      end else if (m_in_trap) begin
        if (bus.mret_i) m_in_trap = 0;
        else if (bus.csr_req_i) begin
          m_grant = 1; m_csr_left = CSR_CYCLES; m_ret = 1; m_in_trap = 0;
        end
      end else begin
        m_win = -1;
        for (int i = 0; i < NUM_SRC; i++)
          if (m_win < 0 && bus.exc_valid_i[i]) m_win = i;
        if (m_win >= 0) begin
          m_taken = 1; m_in_trap = 1;
          m_consumed = '0;
          m_consumed[m_win] = 1'b1;
          m_cause = {1'b0, bus.exc_cause_i[m_win*CAUSE_W +: CAUSE_W]};
          m_epc   = bus.exc_pc_i[m_win*XLEN +: XLEN];
          m_tval  = bus.exc_tval_i[m_win*XLEN +: XLEN];
          exp_q.push_back({m_cause, m_epc, m_tval});
        end else if (bus.mstatus_mie_i && bus.irq_i != 3'b000) begin
          m_taken = 1; m_in_trap = 1;
          m_cause = bus.irq_i[2] ? 6'd43 : (bus.irq_i[1] ? 6'd35 : 6'd39);
          m_epc   = bus.irq_pc_i;
          m_tval  = '0;
          exp_q.push_back({m_cause, m_epc, m_tval});
        end else if (bus.csr_req_i) begin
          m_grant = 1; m_csr_left = CSR_CYCLES; m_ret = 0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic [REC_W-1:0] rec;
  always @(negedge clk) begin
    check("trap_taken",  64'(bus.trap_taken_o),     64'(m_taken));
    check("csr_grant",   64'(bus.csr_grant_o),      64'(m_grant));
    check("csr_access",  64'(bus.csr_access_req_o), 64'(m_grant));
    check("csr_busy",    64'(bus.csr_busy_o),       64'(m_csr_left > 0));
    check("trap_active", 64'(bus.trap_active_o),    64'(m_in_trap || (m_csr_left > 0 && m_ret)));
    check("consumed",    64'(bus.exc_consumed_o),   64'(m_consumed));
    check("mcause",      64'(bus.mcause_o),         64'(m_cause));
    check("mepc",        bus.mepc_o,                m_epc);
    check("mtval",       bus.mtval_o,               m_tval);
    if (bus.trap_taken_o) begin
      check("trap_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        rec = exp_q.pop_front();
        check("sb_mcause", 64'(bus.mcause_o), 64'(rec[REC_W-1 -: CAUSE_W+1]));
        check("sb_mepc",   bus.mepc_o,        rec[2*XLEN-1 -: XLEN]);
        check("sb_mtval",  bus.mtval_o,       rec[XLEN-1:0]);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    clear_inputs();
    // Reset held with every input active.
    bus.exc_valid_i = 4'hF; bus.irq_i = 3'b111; bus.mstatus_mie_i = 1'b1;
    bus.csr_req_i = 1'b1; bus.mret_i = 1'b1;
    set_exc(0, 5'd9, 64'hAA, 64'hBB);
    repeat (3) tick();
    check("rst_taken",  64'(bus.trap_taken_o), 64'd0);
    check("rst_grant",  64'(bus.csr_grant_o), 64'd0);
    check("rst_busy",   64'(bus.csr_busy_o), 64'd0);
    check("rst_active", 64'(bus.trap_active_o), 64'd0);
    check("rst_cons",   64'(bus.exc_consumed_o), 64'd0);
    check("rst_mcause", 64'(bus.mcause_o), 64'd0);
    check("rst_mepc",   bus.mepc_o, 64'd0);
    check("rst_state",  64'(dut_state), 64'd0);
    clear_inputs();
    rst_n = 1'b1;
    tick();
    check("post_rst_state", 64'(dut_state), 64'd0);

    // Two exceptions: source 1 beats source 3.
    set_exc(1, 5'd2, 64'h1000, 64'hDEAD);
    set_exc(3, 5'd8, 64'h3000, 64'hBEEF);
    bus.exc_valid_i = 4'b1010;
    tick();
    check("exc_taken",  64'(bus.trap_taken_o), 64'd1);
    check("exc_cons",   64'(bus.exc_consumed_o), 64'h2);
    check("exc_mcause", 64'(bus.mcause_o), 64'h02);
    check("exc_mepc",   bus.mepc_o, 64'h1000);
    check("exc_mtval",  bus.mtval_o, 64'hDEAD);
    bus.exc_valid_i = '0;
    tick();
    check("exc_pulse_1cyc", 64'(bus.trap_taken_o), 64'd0);
    check("exc_active",     64'(bus.trap_active_o), 64'd1);
    bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
    check("mret_active", 64'(bus.trap_active_o), 64'd0);
    check("mret_keep",   64'(bus.mcause_o), 64'h02);

    // All interrupts pending: MEI wins.
    bus.irq_i = 3'b111; bus.mstatus_mie_i = 1'b1; bus.irq_pc_i = 64'h2000;
    tick();
    check("irq_taken",  64'(bus.trap_taken_o), 64'd1);
    check("irq_cons",   64'(bus.exc_consumed_o), 64'd0);
    check("irq_mcause", 64'(bus.mcause_o), 64'h2B);
    check("irq_mepc",   bus.mepc_o, 64'h2000);
    check("irq_mtval",  bus.mtval_o, 64'd0);
    bus.irq_i = 3'b000; bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
    bus.irq_i = 3'b111; bus.mstatus_mie_i = 1'b0;
    tick();
    check("irq_masked_0", 64'(bus.trap_taken_o), 64'd0);
    tick();
    check("irq_masked_1", 64'(bus.trap_active_o), 64'd0);
    bus.irq_i = 3'b000;

    // Exception and CSR request in the same cycle: the trap wins, then CSR
    // runs inside the trap.
    set_exc(0, 5'd5, 64'h4000, 64'h44);
    bus.exc_valid_i = 4'b0001; bus.csr_req_i = 1'b1;
    tick();
    check("tc_taken", 64'(bus.trap_taken_o), 64'd1);
    check("tc_grant", 64'(bus.csr_grant_o), 64'd0);
    bus.exc_valid_i = '0;
    tick();
    check("tc_grant2", 64'(bus.csr_grant_o), 64'd1);
    check("tc_busy1",  64'(bus.csr_busy_o), 64'd1);
    bus.csr_req_i = 1'b0;
    tick();
    check("tc_busy2", 64'(bus.csr_busy_o), 64'd1);
    tick();
    check("tc_done",  64'(bus.csr_busy_o), 64'd0);
    check("tc_back",  64'(bus.trap_active_o), 64'd1);
    bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;

    // Exception arrives during an idle CSR window: it waits for IDLE.
    bus.csr_req_i = 1'b1;
    tick();
    check("cb_grant", 64'(bus.csr_grant_o), 64'd1);
    bus.csr_req_i = 1'b0;
    set_exc(2, 5'd4, 64'h5000, 64'h55);
    bus.exc_valid_i = 4'b0100;
    tick();
    check("cb_wait0", 64'(bus.trap_taken_o), 64'd0);
    tick();
    check("cb_wait1", 64'(bus.trap_taken_o), 64'd0);
    tick();
    check("cb_taken", 64'(bus.trap_taken_o), 64'd1);
    check("cb_cons",  64'(bus.exc_consumed_o), 64'h4);
    bus.exc_valid_i = '0; bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;

    // mret together with a pending exception: one idle cycle, then the new trap.
    set_exc(0, 5'd1, 64'h6100, 64'h61);
    bus.exc_valid_i = 4'b0001;
    tick();
    bus.exc_valid_i = '0;
    tick();
    set_exc(3, 5'd13, 64'h6000, 64'h66);
    bus.exc_valid_i = 4'b1000; bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
    check("mx_gap_active", 64'(bus.trap_active_o), 64'd0);
    check("mx_gap_taken",  64'(bus.trap_taken_o), 64'd0);
    tick();
    check("mx_taken",  64'(bus.trap_taken_o), 64'd1);
    check("mx_cons",   64'(bus.exc_consumed_o), 64'h8);
    check("mx_mcause", 64'(bus.mcause_o), 64'h0D);
    bus.exc_valid_i = '0; bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;

    // mret in IDLE has no effect.
    bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
    check("idle_mret", 64'(dut_state), 64'd0);

    // mret during a CSR access issued from inside a trap: the window ends in IDLE.
    bus.exc_valid_i = 4'b0001;
    tick();
    bus.exc_valid_i = '0; bus.csr_req_i = 1'b1;
    tick();
    bus.csr_req_i = 1'b0; bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
    check("cm_busy",   64'(bus.csr_busy_o), 64'd1);
    check("cm_active", 64'(bus.trap_active_o), 64'd0);
    tick();
    check("cm_idle", 64'(dut_state), 64'd0);

    // Reset during a trap clears the latched context.
    bus.exc_valid_i = 4'b0010;
    tick();
    bus.exc_valid_i = '0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_active", 64'(bus.trap_active_o), 64'd0);
    check("mid_rst_mcause", 64'(bus.mcause_o), 64'd0);
    check("mid_rst_mepc",   bus.mepc_o, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_state", 64'(dut_state), 64'd0);
    tick();

    check("trap_q_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
